// File: rtl/psa_pkg.sv
// Shared definitions for the pattern search engine and its result path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package psa_pkg;

    // Width of a search offset as produced by the engine's found register.
    localparam int PSA_ADDR_W = 15;

    // Value the engine leaves in found when nothing matched. A real match
    // at this offset is indistinguishable from "no match" and is never reported.
    localparam logic [PSA_ADDR_W-1:0] NO_MATCH = 15'h00FF;

    // One-hot collector states.
    typedef enum logic [3:0] {
        MC_IDLE     = 4'b0001,
        MC_COLLECT  = 4'b0010,
        MC_DRAIN    = 4'b0100,
        MC_COMPLETE = 4'b1000
    } mc_state_t;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO holding captured match offsets.
// Latency: a write is visible at rd_data after the write edge; reads consume on the edge.
// Backpressure: writes when full are refused unless a read retires the head on the same edge.
//
// Ports:
//   CLK100MHZ, reset (async, active-low), flush (sync empty)
//   wr_en/wr_data : push side
//   rd_en/rd_data : pop side, rd_data is the current head (0 when empty)
//   full, empty   : occupancy flags
module result_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 16
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd = rd_en & ~empty;
    // A read on the same edge frees the slot being written, so full does not block it.
    assign do_wr = wr_en & (~full | do_rd);

    // Zero when empty so the head never shows stale or uninitialised storage.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/match_collector.sv
// Turns each new match offset from the search engine into a streamed FIFO entry.
// Latency: found change at edge k -> entry written and rd_valid high after edge k+2.
// Backpressure: rd_ready stalls the stream; matches arriving with the FIFO full and no read are dropped (overflow).
//
// Ports:
//   CLK100MHZ, reset (async, active-low), clear (sync flush to IDLE), start (arm one pass)
//   found, done                : engine result register and completion flag
//   rd_valid/rd_data/rd_ready  : result stream
//   match_count, overflow      : saturating matches this pass, sticky drop flag
//   complete, busy             : pass finished and drained / pass in progress
module match_collector
    import psa_pkg::*;
#(
    parameter int ADDR_W  = PSA_ADDR_W,
    parameter int DEPTH   = 16,
    parameter int COUNT_W = 16
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    input  logic               clear,
    input  logic               start,
    input  logic [ADDR_W-1:0]  found,
    input  logic               done,
    output logic               rd_valid,
    output logic [ADDR_W-1:0]  rd_data,
    input  logic               rd_ready,
    output logic [COUNT_W-1:0] match_count,
    output logic               overflow,
    output logic               complete,
    output logic               busy
);

    localparam logic [ADDR_W-1:0]  NO_MATCH_W = ADDR_W'(NO_MATCH);
    localparam logic [COUNT_W-1:0] CNT_ONE    = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] found_q;
    logic [ADDR_W-1:0] last_found;
    logic              done_q;
    logic              done_q2;

    mc_state_t         state_q;
    mc_state_t         state_d;

    logic              arm;
    logic              capture;
    logic              new_match;
    logic              done_rise;
    logic              rd_fire;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_flush;

    // Engine outputs are registered once; all decisions use the registered copies.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            found_q <= NO_MATCH_W;
            done_q  <= 1'b0;
            done_q2 <= 1'b0;
        end else begin
            found_q <= found;
            done_q  <= done;
            done_q2 <= done_q;
        end
    end

    assign new_match = (found_q != last_found) && (found_q != NO_MATCH_W);
    assign done_rise = done_q & ~done_q2;
    assign rd_fire   = rd_valid & rd_ready;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) state_q <= MC_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        capture = 1'b0;
        if (clear) begin
            state_d = MC_IDLE;
        end else begin
            unique case (state_q)
                MC_IDLE: begin
                    if (start) begin
                        arm     = 1'b1;
                        state_d = MC_COLLECT;
                    end
                end
                MC_COLLECT: begin
                    // A match coinciding with the done edge is still captured here.
                    capture = new_match;
                    if (done_rise) state_d = MC_DRAIN;
                end
                MC_DRAIN: begin
                    if (fifo_empty) state_d = MC_COMPLETE;
                end
                MC_COMPLETE: begin
                    if (start) begin
                        arm     = 1'b1;
                        state_d = MC_COLLECT;
                    end
                end
                default: state_d = MC_IDLE;
            endcase
        end
    end

    // Dropped only when full and the head is not leaving on this same edge.
    assign drop       = capture & fifo_full & ~rd_fire;
    assign fifo_flush = clear | arm;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            last_found  <= NO_MATCH_W;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (fifo_flush) begin
            last_found  <= NO_MATCH_W;
            match_count <= '0;
            overflow    <= 1'b0;
        end else if (capture) begin
            last_found <= found_q;
            if (match_count != '1) match_count <= match_count + CNT_ONE;
            if (drop) overflow <= 1'b1;
        end
    end

    result_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .flush     (fifo_flush),
        .wr_en     (capture),
        .wr_data   (found_q),
        .rd_en     (rd_fire),
        .rd_data   (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_valid = ~fifo_empty;
    assign complete = (state_q == MC_COMPLETE);
    assign busy     = (state_q == MC_COLLECT) || (state_q == MC_DRAIN);

endmodule

// File: tb/tb_match_collector.sv
// Self-checking bench for match_collector: directed scenarios plus randomized passes
// checked against a queue-based model of which offsets should stream out.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_match_collector;

    localparam logic [14:0] SENT = 15'h00FF;

    logic        CLK100MHZ = 1'b0;
    logic        reset;
    logic        clear;
    logic        start;
    logic [14:0] found;
    logic        done;
    logic        rd_valid;
    logic [14:0] rd_data;
    logic        rd_ready;
    logic [15:0] match_count;
    logic        overflow;
    logic        complete;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [14:0] exp_q[$];

    always #5 CLK100MHZ = ~CLK100MHZ;

    match_collector dut (
        .CLK100MHZ   (CLK100MHZ),
        .reset       (reset),
        .clear       (clear),
        .start       (start),
        .found       (found),
        .done        (done),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .match_count (match_count),
        .overflow    (overflow),
        .complete    (complete),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    // Park found at the sentinel so the new pass sees no stale offset, then pulse start.
    task automatic start_pass();
        found    = SENT;
        done     = 1'b0;
        rd_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; start = 1'b0; found = SENT; done = 1'b0; rd_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 15'd0 || match_count !== 16'd0 ||
            overflow !== 1'b0 || complete !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals got v=%b d=%0d c=%0d o=%b cp=%b b=%b want all 0",
                     rd_valid, rd_data, match_count, overflow, complete, busy);
        end
    endtask

    task automatic test_basic();
        logic [14:0] vals [3];
        vals = '{15'd3, 15'd17, 15'd40};
        start_pass();
        total++;
        if (busy !== 1'b1 || match_count !== 16'd0) begin
            bad++; $display("FAIL basic_arm busy=%b count=%0d want 1/0", busy, match_count);
        end
        for (int i = 0; i < 3; i++) begin
            found = vals[i];
            exp_q.push_back(vals[i]);
            tick();
            if (i == 0) begin
                total++;
                if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_lat1 rd_valid=%b want 0", rd_valid); end
            end
            tick();
            if (i == 0) begin
                total++;
                if (rd_valid !== 1'b1 || rd_data !== 15'd3 || match_count !== 16'd1) begin
                    bad++; $display("FAIL basic_lat2 v=%b d=%0d c=%0d want 1/3/1", rd_valid, rd_data, match_count);
                end
            end
            repeat (6) tick();
        end
        done = 1'b1;
        tick(); tick();
        total++;
        if (busy !== 1'b1 || complete !== 1'b0 || match_count !== 16'd3) begin
            bad++; $display("FAIL basic_drain busy=%b cp=%b c=%0d want 1/0/3", busy, complete, match_count);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 20 && rd_valid === 1'b1; i++) begin
            total++;
            if (exp_q.size() == 0 || rd_data !== exp_q[0]) begin
                bad++; $display("FAIL basic_read got=%0d want=%0d", rd_data, exp_q.size() ? exp_q[0] : 15'h7fff);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            tick();
        end
        rd_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL basic_left got=%0d entries want=0", exp_q.size()); end
        tick();
        total++;
        if (complete !== 1'b1 || busy !== 1'b0 || match_count !== 16'd3 || overflow !== 1'b0) begin
            bad++; $display("FAIL basic_done cp=%b b=%b c=%0d o=%b want 1/0/3/0", complete, busy, match_count, overflow);
        end
    endtask

    task automatic test_sentinel();
        logic [14:0] seq [4];
        seq = '{SENT, 15'd5, 15'd5, SENT};
        start_pass();
        for (int i = 0; i < 4; i++) begin
            found = seq[i];
            repeat (10) tick();
        end
        total++;
        if (match_count !== 16'd1 || rd_valid !== 1'b1 || rd_data !== 15'd5) begin
            bad++; $display("FAIL sentinel_cap c=%0d v=%b d=%0d want 1/1/5", match_count, rd_valid, rd_data);
        end
        done = 1'b1;
        tick(); tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        total++;
        if (rd_valid !== 1'b0) begin bad++; $display("FAIL sentinel_single rd_valid=%b want 0", rd_valid); end
        tick();
        total++;
        if (complete !== 1'b1) begin bad++; $display("FAIL sentinel_complete got=%b want 1", complete); end
    endtask

    task automatic test_overflow();
        logic [14:0] v;
        start_pass();
        total++;
        if (overflow !== 1'b0 || match_count !== 16'd0) begin
            bad++; $display("FAIL ovf_arm o=%b c=%0d want 0/0", overflow, match_count);
        end
        for (int i = 0; i < 18; i++) begin
            v = 15'(1000 + i * 5 + int'($urandom_range(0, 3)));
            found = v;
            if (i < 16) exp_q.push_back(v);
            repeat (8) tick();
            if (i == 15) begin
                total++;
                if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want 0", overflow); end
            end
        end
        total++;
        if (overflow !== 1'b1 || match_count !== 16'd18) begin
            bad++; $display("FAIL ovf_flag o=%b c=%0d want 1/18", overflow, match_count);
        end
        done = 1'b1;
        tick(); tick();
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && rd_valid === 1'b1; i++) begin
            total++;
            if (exp_q.size() == 0 || rd_data !== exp_q[0]) begin
                bad++; $display("FAIL ovf_read got=%0d want=%0d", rd_data, exp_q.size() ? exp_q[0] : 15'h7fff);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            tick();
        end
        rd_ready = 1'b0;
        tick();
        total++;
        if (exp_q.size() != 0 || complete !== 1'b1) begin
            bad++; $display("FAIL ovf_done left=%0d cp=%b want 0/1", exp_q.size(), complete);
        end
    endtask

    task automatic test_full_read();
        start_pass();
        for (int i = 0; i < 16; i++) begin
            found = 15'(200 + i);
            exp_q.push_back(15'(200 + i));
            repeat (8) tick();
        end
        found = 15'd300;
        tick();
        // Read the head on the very edge that writes the 17th entry.
        rd_ready = 1'b1;
        total++;
        if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
            bad++; $display("FAIL full_head got=%0d want=%0d", rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tick();
        rd_ready = 1'b0;
        exp_q.push_back(15'd300);
        total++;
        if (overflow !== 1'b0 || match_count !== 16'd17) begin
            bad++; $display("FAIL full_nodrop o=%b c=%0d want 0/17", overflow, match_count);
        end
        repeat (6) tick();
        done = 1'b1;
        tick(); tick();
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && rd_valid === 1'b1; i++) begin
            total++;
            if (exp_q.size() == 0 || rd_data !== exp_q[0]) begin
                bad++; $display("FAIL full_read got=%0d want=%0d", rd_data, exp_q.size() ? exp_q[0] : 15'h7fff);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            tick();
        end
        rd_ready = 1'b0;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL full_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_same_cycle();
        start_pass();
        found = 15'd9;
        done  = 1'b1;
        tick(); tick();
        total++;
        if (rd_valid !== 1'b1 || rd_data !== 15'd9 || match_count !== 16'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL same_cap v=%b d=%0d c=%0d b=%b want 1/9/1/1", rd_valid, rd_data, match_count, busy);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        total++;
        if (rd_valid !== 1'b0 || complete !== 1'b0) begin
            bad++; $display("FAIL same_read v=%b cp=%b want 0/0", rd_valid, complete);
        end
        tick();
        total++;
        if (complete !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL same_done cp=%b b=%b want 1/0", complete, busy);
        end
    endtask

    task automatic test_random();
        logic [14:0] v;
        logic [14:0] last_cap;
        logic [14:0] held;
        logic        hold;
        int          n, step, next_at, done_at, cnt, r;
        for (int pass = 0; pass < 3; pass++) begin
            start_pass();
            n = int'($urandom_range(6, 16));
            step = 0; next_at = 0; done_at = -1; cnt = 0; hold = 1'b0; held = '0;
            last_cap = SENT;
            for (int cyc = 0; cyc < 400; cyc++) begin
                if (step < n && cyc == next_at) begin
                    r = int'($urandom_range(0, 9));
                    if (r < 2)      v = SENT;
                    else if (r < 4) v = last_cap;
                    else            v = 15'($urandom_range(0, 32767));
                    found = v;
                    // A capture is any non-sentinel offset differing from the last captured one.
                    if (v !== SENT && v !== last_cap) begin
                        exp_q.push_back(v);
                        last_cap = v;
                        cnt++;
                    end
                    step++;
                    next_at = cyc + int'($urandom_range(8, 11));
                    if (step == n) done_at = next_at;
                end
                if (cyc == done_at) done = 1'b1;
                rd_ready = 1'($urandom_range(0, 1));
                if (hold) begin
                    total++;
                    if (rd_valid !== 1'b1 || rd_data !== held) begin
                        bad++; $display("FAIL rnd_stable v=%b d=%0d want 1/%0d", rd_valid, rd_data, held);
                    end
                end
                if (rd_valid === 1'b1 && rd_ready) begin
                    total++;
                    if (exp_q.size() == 0 || rd_data !== exp_q[0]) begin
                        bad++; $display("FAIL rnd_read got=%0d want=%0d", rd_data, exp_q.size() ? exp_q[0] : 15'h7fff);
                    end
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                hold = (rd_valid === 1'b1) && !rd_ready;
                held = rd_data;
                if (complete === 1'b1) break;
                tick();
            end
            rd_ready = 1'b0;
            total++;
            if (complete !== 1'b1 || exp_q.size() != 0 || match_count !== 16'(cnt) || overflow !== 1'b0) begin
                bad++; $display("FAIL rnd_pass cp=%b left=%0d c=%0d o=%b want 1/0/%0d/0",
                                complete, exp_q.size(), match_count, overflow, cnt);
            end
        end
    endtask

    task automatic test_clear();
        start_pass();
        for (int i = 0; i < 4; i++) begin
            found = 15'(60 + i);
            repeat (8) tick();
        end
        total++;
        if (match_count !== 16'd4 || rd_valid !== 1'b1) begin
            bad++; $display("FAIL clear_pre c=%0d v=%b want 4/1", match_count, rd_valid);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++;
        if (rd_valid !== 1'b0 || match_count !== 16'd0 || busy !== 1'b0 || complete !== 1'b0) begin
            bad++; $display("FAIL clear_idle v=%b c=%0d b=%b cp=%b want 0/0/0/0", rd_valid, match_count, busy, complete);
        end
        found = 15'd77;
        repeat (3) tick();
        total++;
        if (rd_valid !== 1'b0 || match_count !== 16'd0) begin
            bad++; $display("FAIL clear_nocap v=%b c=%0d want 0/0", rd_valid, match_count);
        end
    endtask

    task automatic test_reset_async();
        start_pass();
        for (int i = 0; i < 3; i++) begin
            found = 15'(500 + i);
            repeat (8) tick();
        end
        done = 1'b1;
        tick(); tick();
        total++;
        if (busy !== 1'b1 || rd_valid !== 1'b1) begin
            bad++; $display("FAIL areset_pre b=%b v=%b want 1/1", busy, rd_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (rd_valid !== 1'b0 || rd_data !== 15'd0 || match_count !== 16'd0 ||
            overflow !== 1'b0 || complete !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL areset_vals v=%b d=%0d c=%0d o=%b cp=%b b=%b want all 0",
                            rd_valid, rd_data, match_count, overflow, complete, busy);
        end
        done = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sentinel();
        test_overflow();
        test_full_read();
        test_same_cycle();
        test_random();
        test_clear();
        test_reset_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/match_collector.md
# match_collector

Downstream stage of the pattern search engine. Watches the engine's `found` result register and `done` flag, turns each new match offset into a FIFO entry, and presents the entries to the host/display side over a valid/ready stream. It also keeps a saturating match count and a sticky overflow flag.

## Interface
- `ADDR_W`, default 15: width of a match offset; equals the search engine's `found` width.
- `DEPTH`, default 16: result FIFO depth; power of two, at least 2.
- `COUNT_W`, default 16: width of the match counter.
- `CLK100MHZ  input  1`: the only clock.
- `reset  input  1`: asynchronous reset, active-low (asserted at 0).
- `clear  input  1`: synchronous flush to IDLE. Has priority over `start`.
- `start  input  1`: one-cycle pulse that arms collection for one search pass.
- `found  input  ADDR_W`: the search engine's `found` register.
- `done  input  1`: the search engine's `done` flag.
- `rd_valid  output  1`: the FIFO head is valid.
- `rd_data  output  ADDR_W`: the FIFO head offset.
- `rd_ready  input  1`: consumer accepts the head.
- `match_count  output  COUNT_W`: matches seen this pass. Saturating. Counts dropped entries too.
- `overflow  output  1`: sticky; set when a match was dropped because the FIFO was full.
- `complete  output  1`: pass finished and FIFO drained.
- `busy  output  1`: high in COLLECT or DRAIN.

## Operation
- Input stage: `found` and `done` are registered into `found_q`, `done_q`, and `done_q2`. Every comparison uses the registered values.
- `NO_MATCH` is 15'h00FF, the engine's "not found" value. Because of this, a genuine match at offset 255 cannot be reported. This is an accepted limitation.
- A new match is detected when `found_q != last_found` and `found_q != NO_MATCH`. On a new match, `last_found` is loaded with `found_q`.
- States are one-hot: IDLE, COLLECT, DRAIN, COMPLETE.
- **IDLE**
  - No captures.
  - On `start`: `last_found` is set to NO_MATCH, the FIFO, `match_count` and `overflow` are cleared, and the state moves to COLLECT.
- **COLLECT**
  - Each new match is written to the FIFO and `match_count` is incremented.
  - A rising edge of `done_q` (`done_q & ~done_q2`) moves the state to DRAIN.
  - If a new match and the `done` edge occur in the same cycle, the match is captured first, then the state moves to DRAIN.
- **DRAIN**
  - No further captures.
  - When the FIFO is empty, the state moves to COMPLETE. If the FIFO is already empty, this happens on the next cycle.
- **COMPLETE**
  - `complete` is 1.
  - `start` re-arms as from IDLE, going straight to COLLECT.
  - `clear` moves to IDLE.
- **FIFO rules**
  - Write when full with `rd_ready & rd_valid` in the same cycle: the read and the write both succeed.
  - Write when full with no read: the entry is dropped, `overflow` is set to 1, and `match_count` still increments.
  - Read when empty is ignored.
- **Counter**: `match_count` saturates at 2^COUNT_W−1 and does not wrap.
- **clear**: in any state, empties the FIFO, zeroes `match_count` and `overflow`, and moves to IDLE on the next edge.
- **Reset**: asynchronous reset mid-pass abandons the pass immediately. All outputs take their reset values.

## Timing
- Reset values:
  - `rd_valid`=0, `rd_data`=0
  - `match_count`=0, `overflow`=0, `complete`=0, `busy`=0
  - state IDLE, `last_found`=NO_MATCH
- Latency: `found` changes at edge k → `found_q` updates at k+1 → FIFO write at k+2 → `rd_valid` is high after edge k+2. `match_count` updates at the same edge k+2.
- The FIFO is first-word-fall-through. `rd_data` is stable while `rd_valid` is high and `rd_ready` is low.
- A transfer happens on each edge where `rd_valid & rd_ready`. Back-to-back reads sustain one entry per cycle.
- `done` edge at edge k → state is DRAIN after edge k+2.
- Throughput: one capture per cycle. The engine produces at most one match per ≥8 cycles.

## Structure
- Shared package `psa_pkg` holds:
  - `NO_MATCH`
  - the one-hot state constants `MC_IDLE`, `MC_COLLECT`, `MC_DRAIN`, `MC_COMPLETE`
  - the default `ADDR_W`
- One sub-module, `result_fifo`:
  - synchronous first-word-fall-through FIFO
  - parameters `WIDTH` and `DEPTH`
  - ports `full`, `empty`, `wr_en`, `wr_data`, `rd_en`, `rd_data`
  - pointers carry an extra wrap bit for full/empty detection
- `match_collector` contains the input registers, match detection, state machine, counter and overflow logic.

## Test plan
- Basic pass: `start`, then `found` = 3, 17, 40, then `done` rising, `rd_ready`=1 → reads 3, 17, 40 in order; `match_count`=3; `complete`=1; `overflow`=0.
- Sentinel and repeat filtering: `found` = 0x00FF, 5, 5 (held 10 cycles), 0x00FF → only 5 captured; `match_count`=1.
- Overflow (DEPTH=16): with `rd_ready`=0, present 18 distinct matches → FIFO holds the first 16; `overflow`=1; `match_count`=18. After `done`, the first 16 drain and then `complete`=1.
- Full with simultaneous read: FIFO full, 17th match arrives in the same cycle as a read → no drop; `overflow`=0; the 17th entry is read last.
- Same-cycle match and `done`: `found`→9 and `done`→1 at the same edge → 9 captured; state moves to DRAIN; 9 is readable; `complete` after the read.
- `clear` and `reset` mid-pass:
  - `clear` in COLLECT with 4 entries queued → next cycle IDLE, `rd_valid`=0, `match_count`=0.
  - `reset` driven to 0 asynchronously mid-DRAIN → all outputs go to their reset values without waiting for a clock edge.
